spi_adc_sample_scheduler: RTL and testbench
===========================================

Name: spi_adc_sample_scheduler

Overview:
- Sequences the serial ADC front end: one 16-bit conversion every SAMPLE_PERIOD clocks. Generates spi_chipselect and spi_clock, shifts in spi_data MSB first, and hands the sample to the clap-detection datapath over a valid/ready handshake.
- Replaces ad hoc SPI timing in top-level logic.
- The ADC changes spi_data after each spi_clock falling edge; this block samples it before each rising edge.

Parameters:
- SAMPLE_WIDTH, 16: bits per conversion.
- CLOCK_DIV, 4: system clocks per spi_clock half-period. Must be >= 2.
- SAMPLE_PERIOD, 256: clocks between conversion starts. Must be >= (2*SAMPLE_WIDTH+3)*CLOCK_DIV; elaboration fails otherwise.

Ports:
- clock, in, 1: system clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: run conversions while high.
- spi_clock, out, 1: SPI clock; idles high (CPOL=1).
- spi_chipselect, out, 1: active-low ADC select.
- spi_data, in, 1: serial data from ADC.
- sample_data, out, SAMPLE_WIDTH: last completed sample.
- sample_valid, out, 1: sample_data holds an unconsumed sample.
- sample_ready, in, 1: consumer accepts when valid and ready are both high.
- busy, out, 1: high in any state other than IDLE.
- overrun, out, 1: sticky; a completed sample was dropped.

Behaviour:
- Reset values:
  - spi_clock=1, spi_chipselect=1.
  - sample_data=0, sample_valid=0, busy=0, overrun=0.
  - State IDLE; all counters 0.
- Reset mid-frame aborts on the next edge: outputs go to their reset values and the partial sample is discarded.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: chipselect=1, spi_clock=1.
    - Start a conversion when enable=1 and either (a) this is the first start since enable rose or since reset, or (b) period_cnt=SAMPLE_PERIOD-1.
    - On start: go to SETUP and set period_cnt to 0.
  - SETUP: chipselect=0, spi_clock=1 for CLOCK_DIV cycles, then go to SHIFT.
  - SHIFT: SAMPLE_WIDTH bit periods, each CLOCK_DIV cycles low then CLOCK_DIV cycles high.
    - In the last cycle of each low half, capture spi_data into the shift register (shift left, MSB arrives first), coincident with spi_clock rising.
    - After the final high half, go to HOLD.
  - HOLD: chipselect=0, spi_clock=1 for CLOCK_DIV cycles.
  - GAP: chipselect=1 for CLOCK_DIV cycles, then go to IDLE.
    - Publish happens on the first GAP cycle.
- period_cnt: increments every cycle from the start of a conversion and saturates at SAMPLE_PERIOD-1. It is held at 0 while enable=0 in IDLE.
- Timeline with defaults, cycle 0 = first SETUP cycle:
  - SETUP cycles 0-3.
  - SHIFT cycles 4-131; spi_clock low 4-7, high 8-11, and so on.
  - HOLD 132-135.
  - Publish and chipselect=1 at cycle 136.
  - GAP 136-139.
  - Next start at cycle 256.
- Publish rules:
  - If sample_valid=0, or sample_valid=1 with sample_ready=1 in the same cycle: load sample_data and set sample_valid=1.
  - If sample_valid=1 and sample_ready=0: keep the old sample and set overrun=1. overrun clears only on reset.
  - Handshake with no publish: sample_valid falls the cycle after acceptance. sample_data holds its value until the next load.
- enable falling mid-frame: the current conversion completes and publishes, then the block stays in IDLE.
- enable rising: SETUP is entered on the next cycle.
- sample_ready is ignored while sample_valid=0.

Test Plan:
- Defaults, enable=1, bench drives 16'hA5C3 MSB first on each spi_clock falling edge:
  - chipselect falls at cycle 0.
  - Exactly 16 spi_clock rising edges.
  - sample_valid=1 with sample_data=16'hA5C3 at cycle 136.
  - chipselect=1 at cycle 136.
- Free-running with sample_ready=1, samples 16'h0001, 16'h8000, 16'hFFFF:
  - Conversion starts spaced exactly 256 cycles apart.
  - Each value accepted in order; overrun=0.
- sample_ready=0 across two conversions (16'h1234, then 16'h5678):
  - sample_data stays 16'h1234 and overrun=1.
  - Raise ready: one accept, sample_valid=0 the next cycle.
- sample_ready=1 exactly on the publish cycle of the second sample while the first is pending:
  - sample_data becomes the second sample, sample_valid stays 1, overrun stays 0.
- reset pulsed at cycle 70 of a conversion:
  - Next cycle: chipselect=1, spi_clock=1, busy=0, sample_valid=0.
  - A new conversion starts the cycle after reset drops (enable=1).
- enable dropped at cycle 50:
  - The frame completes and publishes at cycle 136.
  - No further chipselect activity for 1000 cycles.

Source files
------------

// File: rtl/spi_adc_sample_scheduler_if.sv
// SPI ADC wires plus the sample valid/ready handshake toward the consumer.
// master = scheduler side, slave = ADC/consumer side.
interface spi_adc_sample_scheduler_if #(
   parameter int SAMPLE_WIDTH = 16
);
   logic                    spi_clock;
   logic                    spi_chipselect;
   logic                    spi_data;
   logic [SAMPLE_WIDTH-1:0] sample_data;
   logic                    sample_valid;
   logic                    sample_ready;

   modport master (
      output spi_clock, spi_chipselect, sample_data, sample_valid,
      input  spi_data, sample_ready
   );

   modport slave (
      input  spi_clock, spi_chipselect, sample_data, sample_valid,
      output spi_data, sample_ready
   );
endinterface

// File: rtl/spi_adc_sample_scheduler.sv
// Periodic SPI ADC conversion sequencer (CPOL=1, MSB first) that publishes
// each sample over valid/ready and flags dropped samples with a sticky overrun.
module spi_adc_sample_scheduler #(
   parameter int SAMPLE_WIDTH  = 16,
   parameter int CLOCK_DIV     = 4,
   parameter int SAMPLE_PERIOD = 256
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   spi_adc_sample_scheduler_if.master      bus,
   output logic                            busy,
   output logic                            overrun
);
   localparam int DW = $clog2(CLOCK_DIV);
   localparam int BW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam logic [DW-1:0] DIV_LAST    = DW'(CLOCK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(SAMPLE_WIDTH - 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);

   generate
      if (CLOCK_DIV < 2 || SAMPLE_PERIOD < (2*SAMPLE_WIDTH + 3)*CLOCK_DIV) begin : g_bad_params
         $error("spi_adc_sample_scheduler: CLOCK_DIV/SAMPLE_PERIOD too small for one frame");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t                  state;
   logic [DW-1:0]           div_cnt;
   logic [BW-1:0]           bit_cnt;
   logic [PW-1:0]           period_cnt;
   logic                    phase_high;
   logic                    first_start;
   logic [SAMPLE_WIDTH-1:0] shreg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= IDLE;
         div_cnt            <= '0;
         bit_cnt            <= '0;
         period_cnt         <= '0;
         phase_high         <= 1'b0;
         first_start        <= 1'b1;
         shreg              <= '0;
         bus.spi_clock      <= 1'b1;
         bus.spi_chipselect <= 1'b1;
         bus.sample_data    <= '0;
         bus.sample_valid   <= 1'b0;
         busy               <= 1'b0;
         overrun            <= 1'b0;
      end else begin
         // Re-arm the immediate start whenever enable is low so a rising edge starts at once.
         if (!enable)
            first_start <= 1'b1;

         if (state == IDLE && !enable)
            period_cnt <= '0;
         else if (period_cnt != PERIOD_LAST)
            period_cnt <= period_cnt + 1'b1;

         // Consumer handshake; a publish on the same edge overrides the clear below.
         if (bus.sample_valid && bus.sample_ready)
            bus.sample_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (enable && (first_start || period_cnt == PERIOD_LAST)) begin
                  state              <= SETUP;
                  period_cnt         <= '0;
                  first_start        <= 1'b0;
                  div_cnt            <= '0;
                  bus.spi_chipselect <= 1'b0;
                  busy               <= 1'b1;
               end
            end
            SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  state         <= SHIFT;
                  div_cnt       <= '0;
                  bit_cnt       <= '0;
                  phase_high    <= 1'b0;
                  bus.spi_clock <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (!phase_high) begin
                     // Sample just before the rising edge; ADC data settled after the fall.
                     shreg         <= {shreg[SAMPLE_WIDTH-2:0], bus.spi_data};
                     phase_high    <= 1'b1;
                     bus.spi_clock <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     state <= HOLD;
                  end else begin
                     bit_cnt       <= bit_cnt + 1'b1;
                     phase_high    <= 1'b0;
                     bus.spi_clock <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (div_cnt == DIV_LAST) begin
                  state              <= GAP;
                  div_cnt            <= '0;
                  bus.spi_chipselect <= 1'b1;
                  if (!bus.sample_valid || bus.sample_ready) begin
                     bus.sample_data  <= shreg;
                     bus.sample_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            GAP: begin
               if (div_cnt == DIV_LAST) begin
                  state   <= IDLE;
                  div_cnt <= '0;
                  busy    <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_adc_sample_scheduler.sv
// Directed bench for spi_adc_sample_scheduler with a behavioural MSB-first ADC.
// Cycle 0 is the first SETUP cycle; outputs are sampled 1 ns after each rising clock.
module tb_spi_adc_sample_scheduler;
   logic clock;
   logic reset;
   logic enable;
   logic busy;
   logic overrun;

   spi_adc_sample_scheduler_if #(.SAMPLE_WIDTH(16)) bus ();

   spi_adc_sample_scheduler #(
      .SAMPLE_WIDTH(16),
      .CLOCK_DIV(4),
      .SAMPLE_PERIOD(256)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .bus    (bus.master),
      .busy   (busy),
      .overrun(overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rise_cnt = 0;
   logic [15:0] adc_q[$];
   logic [15:0] adc_cur = '0;
   int          adc_idx = 15;

   // ADC model: a new word on chipselect fall (spi_clock is high then),
   // next bit after every spi_clock fall while selected.
   always @(negedge bus.spi_chipselect or negedge bus.spi_clock) begin
      if (!bus.spi_chipselect && bus.spi_clock) begin
         adc_cur = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
         adc_idx = 15;
      end else if (!bus.spi_chipselect && !bus.spi_clock) begin
         bus.spi_data = adc_cur[adc_idx];
         adc_idx = (adc_idx > 0) ? adc_idx - 1 : 0;
      end
   end

   always @(posedge bus.spi_clock)
      if (!bus.spi_chipselect) rise_cnt++;

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic adv_to(input int target);
      while (cyc < target) tick();
   endtask

   // Reset, then raise enable so the next edge enters SETUP; returns at cycle 0.
   task automatic start_conv();
      enable = 1'b0;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
      tick();
      rise_cnt = 0;
      enable   = 1'b1;
      tick();
      cyc = 0;
   endtask

   task automatic test_reset();
      enable = 1'b0;
      bus.sample_ready = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      total++;
      if ({bus.spi_clock, bus.spi_chipselect, bus.sample_valid, busy, overrun} !== 5'b11000) begin
         bad++;
         $display("FAIL reset_ctrl: got clk/cs/valid/busy/ovr=%b expected 11000",
                  {bus.spi_clock, bus.spi_chipselect, bus.sample_valid, busy, overrun});
      end
      total++;
      if (bus.sample_data !== 16'h0000) begin
         bad++;
         $display("FAIL reset_data: got %h expected 0000", bus.sample_data);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      bus.sample_ready = 1'b0;
      adc_q = {16'hA5C3};
      start_conv();
      total++;
      if (bus.spi_chipselect !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_cs_fall: cs=%b busy=%b expected cs=0 busy=1", bus.spi_chipselect, busy);
      end
      adv_to(4);
      total++;
      if (bus.spi_clock !== 1'b0) begin
         bad++;
         $display("FAIL single_first_low: spi_clock=%b at cycle 4 expected 0", bus.spi_clock);
      end
      adv_to(135);
      total++;
      if (bus.sample_valid !== 1'b0 || bus.spi_chipselect !== 1'b0) begin
         bad++;
         $display("FAIL single_pre_publish: valid=%b cs=%b expected 0 0", bus.sample_valid, bus.spi_chipselect);
      end
      adv_to(136);
      total++;
      if (bus.sample_valid !== 1'b1 || bus.sample_data !== 16'hA5C3 || bus.spi_chipselect !== 1'b1) begin
         bad++;
         $display("FAIL single_publish: valid=%b data=%h cs=%b expected 1 a5c3 1",
                  bus.sample_valid, bus.sample_data, bus.spi_chipselect);
      end
      total++;
      if (rise_cnt !== 16) begin
         bad++;
         $display("FAIL single_edges: rising edges=%0d expected 16", rise_cnt);
      end
      adv_to(140);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL single_idle: busy=%b at cycle 140 expected 0", busy);
      end
   endtask

   task automatic test_free_running();
      logic [15:0] exp_w[3];
      exp_w[0] = 16'h0001;
      exp_w[1] = 16'h8000;
      exp_w[2] = 16'hFFFF;
      bus.sample_ready = 1'b1;
      adc_q = {16'h0001, 16'h8000, 16'hFFFF};
      start_conv();
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            adv_to(256*k - 1);
            total++;
            if (bus.spi_chipselect !== 1'b1) begin
               bad++;
               $display("FAIL free_gap_%0d: cs=%b at cycle %0d expected 1", k, bus.spi_chipselect, cyc);
            end
            adv_to(256*k);
            total++;
            if (bus.spi_chipselect !== 1'b0) begin
               bad++;
               $display("FAIL free_start_%0d: cs=%b at cycle %0d expected 0", k, bus.spi_chipselect, cyc);
            end
         end
         adv_to(256*k + 136);
         total++;
         if (bus.sample_valid !== 1'b1 || bus.sample_data !== exp_w[k]) begin
            bad++;
            $display("FAIL free_pub_%0d: valid=%b data=%h expected 1 %h", k, bus.sample_valid, bus.sample_data, exp_w[k]);
         end
         adv_to(256*k + 137);
         total++;
         if (bus.sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL free_accept_%0d: valid=%b expected 0", k, bus.sample_valid);
         end
      end
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL free_overrun: overrun=%b expected 0", overrun);
      end
      enable = 1'b0;
   endtask

   task automatic test_overrun();
      bus.sample_ready = 1'b0;
      adc_q = {16'h1234, 16'h5678};
      start_conv();
      adv_to(136);
      total++;
      if (bus.sample_valid !== 1'b1 || bus.sample_data !== 16'h1234 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL ovr_first: valid=%b data=%h ovr=%b expected 1 1234 0",
                  bus.sample_valid, bus.sample_data, overrun);
      end
      adv_to(256 + 136);
      total++;
      if (bus.sample_valid !== 1'b1 || bus.sample_data !== 16'h1234 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL ovr_drop: valid=%b data=%h ovr=%b expected 1 1234 1",
                  bus.sample_valid, bus.sample_data, overrun);
      end
      bus.sample_ready = 1'b1;
      tick();
      bus.sample_ready = 1'b0;
      total++;
      if (bus.sample_valid !== 1'b0 || bus.sample_data !== 16'h1234 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL ovr_accept: valid=%b data=%h ovr=%b expected 0 1234 1",
                  bus.sample_valid, bus.sample_data, overrun);
      end
      enable = 1'b0;
   endtask

   // ready is high only in cycle 391, whose closing edge is the second publish.
   task automatic test_back_to_back();
      bus.sample_ready = 1'b0;
      adc_q = {16'h1111, 16'h2222};
      start_conv();
      adv_to(256 + 135);
      bus.sample_ready = 1'b1;
      tick();
      bus.sample_ready = 1'b0;
      total++;
      if (bus.sample_valid !== 1'b1 || bus.sample_data !== 16'h2222 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL b2b_publish: valid=%b data=%h ovr=%b expected 1 2222 0",
                  bus.sample_valid, bus.sample_data, overrun);
      end
      tick();
      total++;
      if (bus.sample_valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_hold: valid=%b expected 1", bus.sample_valid);
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      bus.sample_ready = 1'b0;
      adc_q = {16'h0F0F, 16'hF0F0};
      start_conv();
      adv_to(256 + 70);
      total++;
      if (bus.spi_clock !== 1'b0 || bus.sample_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_pre: spi_clock=%b valid=%b expected 0 1", bus.spi_clock, bus.sample_valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({bus.spi_chipselect, bus.spi_clock, busy, bus.sample_valid} !== 4'b1100) begin
         bad++;
         $display("FAIL rst_mid_abort: cs/clk/busy/valid=%b expected 1100",
                  {bus.spi_chipselect, bus.spi_clock, busy, bus.sample_valid});
      end
      tick();
      total++;
      if (bus.spi_chipselect !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_restart: cs=%b busy=%b expected 0 1", bus.spi_chipselect, busy);
      end
      enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      int active;
      bus.sample_ready = 1'b0;
      adc_q = {16'hABCD};
      start_conv();
      adv_to(50);
      enable = 1'b0;
      adv_to(135);
      total++;
      if (bus.spi_chipselect !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL en_drop_run: cs=%b busy=%b at cycle 135 expected 0 1", bus.spi_chipselect, busy);
      end
      adv_to(136);
      total++;
      if (bus.sample_valid !== 1'b1 || bus.sample_data !== 16'hABCD) begin
         bad++;
         $display("FAIL en_drop_publish: valid=%b data=%h expected 1 abcd", bus.sample_valid, bus.sample_data);
      end
      adv_to(140);
      active = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (bus.spi_chipselect !== 1'b1 || busy !== 1'b0) active++;
      end
      total++;
      if (active !== 0) begin
         bad++;
         $display("FAIL en_drop_quiet: %0d active cycles expected 0", active);
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      bus.sample_ready = 1'b0;
      test_reset();
      test_single();
      test_free_running();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      test_enable_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
